// File: rtl/playback_sequencer_if.sv
// Bundle between the playback sequencer and its board/ROM/tone-generator side.
// master = sequencer, slave = environment that owns buttons, mode select and song ROM.
interface playback_sequencer_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DUR_W  = 8
);
    logic              btn_prev;
    logic              btn_pause;
    logic              btn_next;
    logic              play_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [4:0]        rom_note;
    logic [DUR_W-1:0]  rom_dur;
    logic [4:0]        note;
    logic [1:0]        song_num;
    logic              paused;
    logic              playing;
    logic              song_done;

    modport master (
        input  btn_prev, btn_pause, btn_next, play_en, rom_note, rom_dur,
        output rom_addr, note, song_num, paused, playing, song_done
    );

    modport slave (
        output btn_prev, btn_pause, btn_next, play_en, rom_note, rom_dur,
        input  rom_addr, note, song_num, paused, playing, song_done
    );
endinterface

// File: rtl/playback_sequencer.sv
// Song-playback controller: debounced prev/pause/next, song select, timed note stepping.
// Optional PLAYBACK_AUTO_NEXT_EN: on end of song advance to the next song and keep playing.
module playback_sequencer #(
    parameter int unsigned NUM_SONGS = 3,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DUR_W     = 8,
    parameter int unsigned BEAT_CYC  = 2_500_000,
    parameter int unsigned GAP_CYC   = 5_000_000,
    parameter int unsigned DB_CYC    = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    playback_sequencer_if.master  bus
);
    localparam int unsigned IDX_W   = ADDR_W - 2;
    localparam int unsigned CNT_MAX = (BEAT_CYC > GAP_CYC) ? BEAT_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned DB_W    = $clog2(DB_CYC + 1);
    localparam logic [1:0]  LAST_SONG = 2'(NUM_SONGS - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_PLAY, S_GAP, S_DONE} state_t;

    // Button conditioning, bit order {next, pause, prev}
    logic [2:0]      raw, sync1, sync2, db_lvl, db_lvl_q, press;
    logic [DB_W-1:0] db_cnt [3];

    assign raw = {bus.btn_next, bus.btn_pause, bus.btn_prev};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            db_lvl   <= '0;
            db_lvl_q <= '0;
            press    <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            db_lvl_q <= db_lvl;
            press    <= db_lvl & ~db_lvl_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DB_CYC - 1)) begin
                    db_lvl[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [DUR_W-1:0] dur_cnt, dur_nxt;
    logic [CNT_W-1:0] cyc_cnt, cyc_nxt;
    logic [4:0]       held_note, held_nxt;
    logic [4:0]       note_r, note_nxt;
    logic [1:0]       song_sel, song_nxt;
    logic             paused_r, paused_nxt;
    logic             playing_r, playing_nxt;
    logic             done_r, done_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            dur_cnt   <= '0;
            cyc_cnt   <= '0;
            held_note <= '0;
            note_r    <= '0;
            song_sel  <= '0;
            paused_r  <= 1'b0;
            playing_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            dur_cnt   <= dur_nxt;
            cyc_cnt   <= cyc_nxt;
            held_note <= held_nxt;
            note_r    <= note_nxt;
            song_sel  <= song_nxt;
            paused_r  <= paused_nxt;
            playing_r <= playing_nxt;
            done_r    <= done_nxt;
        end
    end

    // Sequencing, then overrides in rising priority: end-of-song, song change, mode off
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        dur_nxt     = dur_cnt;
        cyc_nxt     = cyc_cnt;
        held_nxt    = held_note;
        song_nxt    = song_sel;
        paused_nxt  = paused_r;
        done_nxt    = 1'b0;
        note_nxt    = '0;
        playing_nxt = 1'b0;

        if (bus.play_en && press[1]) paused_nxt = ~paused_r;

        case (state)
            S_IDLE:  if (bus.play_en && !paused_r) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.rom_dur == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    held_nxt  = bus.rom_note;
                    dur_nxt   = bus.rom_dur;
                    cyc_nxt   = '0;
                    state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (!paused_r) begin
                    if (cyc_cnt == CNT_W'(BEAT_CYC - 1)) begin
                        cyc_nxt = '0;
                        if (dur_cnt == DUR_W'(1)) begin
                            dur_nxt   = '0;
                            state_nxt = S_GAP;
                        end else begin
                            dur_nxt = dur_cnt - DUR_W'(1);
                        end
                    end else begin
                        cyc_nxt = cyc_cnt + CNT_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (!paused_r) begin
                    if (cyc_cnt == CNT_W'(GAP_CYC - 1)) begin
                        cyc_nxt = '0;
                        if (&idx) begin
                            state_nxt = S_DONE;
                        end else begin
                            idx_nxt   = idx + IDX_W'(1);
                            state_nxt = S_FETCH;
                        end
                    end else begin
                        cyc_nxt = cyc_cnt + CNT_W'(1);
                    end
                end
            end
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase

        if (state_nxt == S_DONE && state != S_DONE) begin
            done_nxt = 1'b1;
`ifdef PLAYBACK_AUTO_NEXT_EN
            song_nxt  = (song_sel == LAST_SONG) ? 2'd0 : song_sel + 2'd1;
            idx_nxt   = '0;
            state_nxt = S_FETCH;
`endif
        end

        // Simultaneous prev+next cancels; change is relative to the registered song
        if (press[2] ^ press[0]) begin
            if (press[2]) song_nxt = (song_sel == LAST_SONG) ? 2'd0 : song_sel + 2'd1;
            else          song_nxt = (song_sel == 2'd0) ? LAST_SONG : song_sel - 2'd1;
            idx_nxt   = '0;
            dur_nxt   = '0;
            cyc_nxt   = '0;
            held_nxt  = '0;
            done_nxt  = 1'b0;
            state_nxt = S_IDLE;
        end

        if (!bus.play_en) begin
            state_nxt  = S_IDLE;
            idx_nxt    = '0;
            dur_nxt    = '0;
            cyc_nxt    = '0;
            paused_nxt = 1'b0;
            done_nxt   = 1'b0;
        end

        note_nxt    = (state_nxt == S_PLAY && !paused_nxt) ? held_nxt : 5'd0;
        playing_nxt = (state_nxt inside {S_FETCH, S_WAIT, S_PLAY, S_GAP}) && !paused_nxt;
    end

    assign bus.rom_addr  = {song_sel, idx};
    assign bus.note      = note_r;
    assign bus.song_num  = song_sel;
    assign bus.paused    = paused_r;
    assign bus.playing   = playing_r;
    assign bus.song_done = done_r;
endmodule

// File: tb/tb_playback_sequencer.sv
// Bench for playback_sequencer: randomized songs checked cycle-by-cycle against a note-timeline model.
module tb_playback_sequencer;
    localparam int NS   = 3;
    localparam int AW   = 6;
    localparam int DW   = 4;
    localparam int BEAT = 4;
    localparam int GAP  = 2;
    localparam int DB   = 3;
    localparam int IDXN = 1 << (AW - 2);
    localparam int HOLD = DB + 6;

    logic clk = 1'b0;
    logic rst;

    playback_sequencer_if #(.ADDR_W(AW), .DUR_W(DW)) bus ();

    playback_sequencer #(
        .NUM_SONGS(NS), .ADDR_W(AW), .DUR_W(DW),
        .BEAT_CYC(BEAT), .GAP_CYC(GAP), .DB_CYC(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    logic [4:0]    rom_note_mem [4*IDXN];
    logic [DW-1:0] rom_dur_mem  [4*IDXN];

    always @(posedge clk) begin
        bus.rom_note <= rom_note_mem[bus.rom_addr];
        bus.rom_dur  <= rom_dur_mem[bus.rom_addr];
    end

    int checks = 0;
    int errors = 0;
    int model_song = 0;

    logic [4:0] exp_note[$];
    bit         exp_play[$];
    bit         exp_done[$];
    bit         exp_pz[$];

    function automatic void push_exp(input logic [4:0] n, input bit p, input bit d, input bit pz);
        exp_note.push_back(n);
        exp_play.push_back(p);
        exp_done.push_back(d);
        exp_pz.push_back(pz);
    endfunction

    // Timeline from play start: per entry 2 silent fetch cycles, dur*BEAT of the note, GAP silent
    function automatic void build_expected(input int song);
        bit auto_next;
`ifdef PLAYBACK_AUTO_NEXT_EN
        auto_next = 1'b1;
`else
        auto_next = 1'b0;
`endif
        exp_note.delete(); exp_play.delete(); exp_done.delete(); exp_pz.delete();
        for (int k = 0; k < IDXN; k++) begin
            int a;
            int d;
            a = song * IDXN + k;
            d = int'(rom_dur_mem[a]);
            push_exp(5'd0, 1'b1, 1'b0, 1'b0);
            push_exp(5'd0, 1'b1, 1'b0, 1'b0);
            if (d == 0) break;
            for (int j = 0; j < d * BEAT; j++) push_exp(rom_note_mem[a], 1'b1, 1'b0, 1'b0);
            for (int j = 0; j < GAP; j++) push_exp(5'd0, 1'b1, 1'b0, 1'b0);
        end
        push_exp(5'd0, auto_next, 1'b1, 1'b0);
        if (!auto_next)
            for (int j = 0; j < 4; j++) push_exp(5'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic load_random_song(input int song);
        int len;
        len = $urandom_range(1, 5);
        for (int k = 0; k < IDXN; k++) begin
            rom_note_mem[song*IDXN+k] = 5'($urandom_range(0, 31));
            rom_dur_mem[song*IDXN+k]  = (k < len) ? DW'($urandom_range(1, 3)) : '0;
        end
    endtask

    task automatic press_btn(input bit p, input bit n);
        @(negedge clk);
        bus.btn_prev = p;
        bus.btn_next = n;
        repeat (HOLD) @(negedge clk);
        bus.btn_prev = 1'b0;
        bus.btn_next = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic select_song(input int target);
        for (int t = 0; t < NS && model_song != target; t++) begin
            press_btn(1'b0, 1'b1);
            model_song = (model_song + 1) % NS;
        end
    endtask

    task automatic stop_play();
        @(negedge clk);
        bus.play_en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.note !== 5'd0 || bus.song_num !== 2'd0 || bus.paused !== 1'b0 ||
            bus.playing !== 1'b0 || bus.song_done !== 1'b0 || bus.rom_addr !== AW'(0)) begin
            errors++;
            $display("FAIL reset_values: note=%0d song=%0d paused=%0b playing=%0b done=%0b addr=%0d, want all 0",
                     bus.note, bus.song_num, bus.paused, bus.playing, bus.song_done, bus.rom_addr);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.playing !== 1'b0 || bus.note !== 5'd0) begin
            errors++;
            $display("FAIL idle_after_reset: playing=%0b note=%0d, want 0 0", bus.playing, bus.note);
        end
    endtask

    task automatic test_song_select();
        int want [4];
        want[0] = 1; want[1] = 2; want[2] = 0; want[3] = 2;
        for (int s = 0; s < 4; s++) begin
            if (s < 3) press_btn(1'b0, 1'b1);
            else       press_btn(1'b1, 1'b0);
            model_song = want[s];
            checks++;
            if (bus.song_num !== 2'(want[s])) begin
                errors++;
                $display("FAIL song_step%0d: song_num=%0d want %0d", s, bus.song_num, want[s]);
            end
        end
        @(negedge clk);
        bus.btn_next = 1'b1;
        repeat (2) @(negedge clk);
        bus.btn_next = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (bus.song_num !== 2'(model_song)) begin
            errors++;
            $display("FAIL glitch_ignored: song_num=%0d want %0d", bus.song_num, model_song);
        end
        for (int s = 0; s < 6; s++) begin
            bit go_next;
            go_next = 1'($urandom_range(0, 1));
            press_btn(!go_next, go_next);
            model_song = go_next ? (model_song + 1) % NS : (model_song + NS - 1) % NS;
            checks++;
            if (bus.song_num !== 2'(model_song)) begin
                errors++;
                $display("FAIL random_select%0d: song_num=%0d want %0d", s, bus.song_num, model_song);
            end
        end
    endtask

    task automatic test_playback_directed();
        rom_note_mem[0] = 5'd5;  rom_dur_mem[0] = DW'(2);
        rom_note_mem[1] = 5'd17; rom_dur_mem[1] = '0;
        select_song(0);
        build_expected(0);
        @(negedge clk);
        bus.play_en = 1'b1;
        for (int i = 0; i < exp_note.size(); i++) begin
            @(negedge clk);
            checks++;
            if (bus.note !== exp_note[i] || bus.playing !== exp_play[i] || bus.song_done !== exp_done[i]) begin
                errors++;
                $display("FAIL directed_c%0d: note=%0d playing=%0b done=%0b want %0d %0b %0b",
                         i, bus.note, bus.playing, bus.song_done, exp_note[i], exp_play[i], exp_done[i]);
            end
        end
        stop_play();
    endtask

    task automatic test_playback_random();
        for (int rep = 0; rep < 4; rep++) begin
            int target;
            for (int s = 0; s < NS; s++) load_random_song(s);
            target = $urandom_range(0, NS - 1);
            select_song(target);
            build_expected(target);
            @(negedge clk);
            bus.play_en = 1'b1;
            for (int i = 0; i < exp_note.size(); i++) begin
                @(negedge clk);
                checks++;
                if (bus.note !== exp_note[i] || bus.playing !== exp_play[i] ||
                    bus.song_done !== exp_done[i] || bus.paused !== 1'b0) begin
                    errors++;
                    $display("FAIL random%0d_c%0d: note=%0d playing=%0b done=%0b paused=%0b want %0d %0b %0b 0",
                             rep, i, bus.note, bus.playing, bus.song_done, bus.paused,
                             exp_note[i], exp_play[i], exp_done[i]);
                end
            end
            stop_play();
        end
    endtask

    // Pause lands after 3 note cycles; 14 frozen cycles follow, then the remaining 5
    task automatic test_pause();
        rom_note_mem[0] = 5'd5;  rom_dur_mem[0] = DW'(2);
        rom_note_mem[1] = 5'd3;  rom_dur_mem[1] = '0;
        select_song(0);
        build_expected(0);
        for (int j = 0; j < 14; j++) begin
            exp_note.insert(5, 5'd0);
            exp_play.insert(5, 1'b0);
            exp_done.insert(5, 1'b0);
            exp_pz.insert(5, 1'b1);
        end
        @(negedge clk);
        bus.btn_pause = 1'b1;
        @(negedge clk);
        bus.play_en = 1'b1;
        for (int i = 0; i < exp_note.size(); i++) begin
            @(negedge clk);
            checks++;
            if (bus.note !== exp_note[i] || bus.playing !== exp_play[i] ||
                bus.song_done !== exp_done[i] || bus.paused !== exp_pz[i]) begin
                errors++;
                $display("FAIL pause_c%0d: note=%0d playing=%0b done=%0b paused=%0b want %0d %0b %0b %0b",
                         i, bus.note, bus.playing, bus.song_done, bus.paused,
                         exp_note[i], exp_play[i], exp_done[i], exp_pz[i]);
            end
            if (i == 6)  bus.btn_pause = 1'b0;
            if (i == 12) bus.btn_pause = 1'b1;
            if (i == 20) bus.btn_pause = 1'b0;
        end
        stop_play();
    endtask

    task automatic test_simultaneous();
        rom_note_mem[0] = 5'd5;  rom_dur_mem[0] = DW'(2);
        rom_note_mem[1] = 5'd9;  rom_dur_mem[1] = DW'(3);
        rom_note_mem[2] = 5'd1;  rom_dur_mem[2] = '0;
        select_song(0);
        build_expected(0);
        @(negedge clk);
        bus.play_en = 1'b1;
        for (int i = 0; i < exp_note.size(); i++) begin
            @(negedge clk);
            checks++;
            if (bus.note !== exp_note[i] || bus.playing !== exp_play[i] || bus.song_done !== exp_done[i]) begin
                errors++;
                $display("FAIL both_btn_c%0d: note=%0d playing=%0b done=%0b want %0d %0b %0b",
                         i, bus.note, bus.playing, bus.song_done, exp_note[i], exp_play[i], exp_done[i]);
            end
            if (i == 0)  begin bus.btn_prev = 1'b1; bus.btn_next = 1'b1; end
            if (i == 10) begin bus.btn_prev = 1'b0; bus.btn_next = 1'b0; end
        end
        checks++;
        if (bus.song_num !== 2'(model_song)) begin
            errors++;
            $display("FAIL both_btn_song: song_num=%0d want %0d", bus.song_num, model_song);
        end
        stop_play();
    endtask

    task automatic test_end_of_region();
        for (int k = 0; k < IDXN; k++) begin
            rom_note_mem[2*IDXN+k] = 5'($urandom_range(1, 31));
            rom_dur_mem[2*IDXN+k]  = DW'(1);
        end
        select_song(2);
        build_expected(2);
        @(negedge clk);
        bus.play_en = 1'b1;
        for (int i = 0; i < exp_note.size(); i++) begin
            @(negedge clk);
            checks++;
            if (bus.note !== exp_note[i] || bus.playing !== exp_play[i] || bus.song_done !== exp_done[i]) begin
                errors++;
                $display("FAIL region_c%0d: note=%0d playing=%0b done=%0b want %0d %0b %0b",
                         i, bus.note, bus.playing, bus.song_done, exp_note[i], exp_play[i], exp_done[i]);
            end
`ifdef PLAYBACK_AUTO_NEXT_EN
            if (exp_done[i]) begin
                checks++;
                if (bus.rom_addr !== AW'(0)) begin
                    errors++;
                    $display("FAIL auto_next_addr: rom_addr=%0d want 0", bus.rom_addr);
                end
            end
`endif
        end
`ifdef PLAYBACK_AUTO_NEXT_EN
        model_song = (model_song + 1) % NS;
`endif
        checks++;
        if (bus.song_num !== 2'(model_song)) begin
            errors++;
            $display("FAIL region_song: song_num=%0d want %0d", bus.song_num, model_song);
        end
        stop_play();
    endtask

    task automatic test_reset_mid_play();
        load_random_song(1);
        rom_note_mem[IDXN] = 5'd6;
        rom_dur_mem[IDXN]  = DW'(3);
        select_song(1);
        @(negedge clk);
        bus.play_en = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.note !== 5'd6) begin
            errors++;
            $display("FAIL pre_reset_note: note=%0d want 6", bus.note);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.note !== 5'd0 || bus.song_num !== 2'd0 || bus.paused !== 1'b0 ||
            bus.playing !== 1'b0 || bus.rom_addr !== AW'(0)) begin
            errors++;
            $display("FAIL async_reset: note=%0d song=%0d paused=%0b playing=%0b addr=%0d want 0",
                     bus.note, bus.song_num, bus.paused, bus.playing, bus.rom_addr);
        end
        model_song = 0;
        build_expected(0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < exp_note.size(); i++) begin
            @(negedge clk);
            checks++;
            if (bus.note !== exp_note[i] || bus.playing !== exp_play[i] || bus.song_done !== exp_done[i] ||
                (i == 0 && bus.rom_addr !== AW'(0))) begin
                errors++;
                $display("FAIL restart_c%0d: note=%0d playing=%0b done=%0b addr=%0d want %0d %0b %0b",
                         i, bus.note, bus.playing, bus.song_done, bus.rom_addr,
                         exp_note[i], exp_play[i], exp_done[i]);
            end
        end
        stop_play();
    endtask

    initial begin
        rst           = 1'b1;
        bus.btn_prev  = 1'b0;
        bus.btn_pause = 1'b0;
        bus.btn_next  = 1'b0;
        bus.play_en   = 1'b0;
        for (int a = 0; a < 4*IDXN; a++) begin
            rom_note_mem[a] = '0;
            rom_dur_mem[a]  = '0;
        end
        test_reset();
        test_song_select();
        test_playback_directed();
        test_playback_random();
        test_pause();
        test_simultaneous();
        test_end_of_region();
        test_reset_mid_play();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/playback_sequencer.md
# playback_sequencer

Clocked playback controller for the piano's song-playback mode. Debounces the prev/pause/next buttons, owns song selection and the pause state, and steps through the selected song in the song ROM, issuing one note code at a time to the tone generator for a timed duration. It sits between the board buttons/mode select and the song ROM + tone generator.

## Interface
- `NUM_SONGS`, 3: songs in ROM (2..4); `song_num` wraps within 0..NUM_SONGS-1.
- `ADDR_W`, 10: ROM address width; address = {song_num[1:0], idx[ADDR_W-3:0]}.
- `DUR_W`, 8: duration field width, in beat units.
- `BEAT_CYC`, 2_500_000: clk cycles per beat unit.
- `GAP_CYC`, 5_000_000: silent cycles inserted after every note.
- `DB_CYC`, 1_000_000: cycles a raw button must be stable to be accepted.
- `clk` in 1: system clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `btn_prev`, `btn_pause`, `btn_next` in 1 each: raw asynchronous buttons, active-high.
- `play_en` in 1: playback mode selected.
- `rom_addr` out ADDR_W: song ROM address.
- `rom_note` in 5: note code from ROM; 0 = rest.
- `rom_dur` in DUR_W: note duration in beats; 0 = end-of-song marker.
- `note` out 5: note code to the tone generator; 0 = silence.
- `song_num` out 2: selected song.
- `paused` out 1: pause state.
- `playing` out 1: high in FETCH/WAIT/PLAY/GAP while not paused.
- `song_done` out 1: one-cycle pulse on end-of-song.

## Operation
- Buttons: 2-FF synchronizer, then stability counter; debounced level changes once the synced input has been stable for DB_CYC consecutive cycles; press = one-cycle pulse on debounced rising edge.
- next press: song_num+1, NUM_SONGS-1 wraps to 0. prev press: song_num-1, 0 wraps to NUM_SONGS-1. Both pulses in the same cycle: ignored. Any song change: idx=0, counters cleared, state→IDLE; paused unchanged. Song select works regardless of play_en.
- pause press toggles `paused` (only when play_en=1).
- play_en=0: state forced to IDLE, idx=0, paused=0, note=0.
- FSM states: IDLE, FETCH, WAIT, PLAY, GAP, DONE.
  - IDLE: note=0; play_en & !paused → FETCH.
  - FETCH: rom_addr presented (always {song_num, idx}) → WAIT.
  - WAIT: rom data valid; rom_dur==0 → DONE; else note←rom_note, dur_cnt←rom_dur, beat_cnt←0 → PLAY.
  - PLAY: beat_cnt counts 0..BEAT_CYC-1; at wrap dur_cnt−1; last beat done → GAP, note←0.
  - GAP: GAP_CYC cycles; then idx+1 → FETCH; if idx was all-ones → DONE (end of ROM region).
  - DONE: song_done pulses on entry; note=0; holds until song change or play_en low.
- Pause: in PLAY/GAP counters freeze and note output is forced to 0; on resume the held note reappears and counting continues where frozen. FETCH/WAIT complete regardless; pause takes effect on reaching PLAY. IDLE does not leave while paused.

## Timing
- Reset values: note=0, song_num=0, paused=0, playing=0, song_done=0, rom_addr=0, state=IDLE, idx=0, all counters 0.
- Button latency: raw edge → press pulse = 2 + DB_CYC + 1 cycles.
- ROM: synchronous, 1-cycle read latency; sampled at the end of WAIT.
- Per note: FETCH(1) + WAIT(1) + PLAY(rom_dur×BEAT_CYC) + GAP(GAP_CYC); note nonzero exactly rom_dur×BEAT_CYC cycles (unpaused, non-rest).
- Song change coinciding with DONE entry: song change wins; no double advance.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous).

## Configuration
- `PLAYBACK_AUTO_NEXT_EN` defined: on DONE entry song_num advances (wraps to 0) and the FSM goes directly to FETCH at idx=0 of the new song; song_done still pulses.
- Not defined: FSM parks in DONE as described; no automatic song change.

## Test plan
(BEAT_CYC=4, GAP_CYC=2, DB_CYC=3)
- play_en=1, song0 ROM = (note 5, dur 2), (x, dur 0) → note=5 for exactly 8 cycles starting 2 cycles after FETCH, 0 for 2 gap cycles, song_done one-cycle pulse, note stays 0 in DONE.
- 3 clean next presses from 0 → song_num 1, 2, 0; one prev press from 0 → 2; 2-cycle glitch on btn_next → no change.
- pause pressed after 3 cycles of note 5 → note=0, playing=0, counters hold; pause again → note=5 for remaining 5 cycles, then GAP.
- prev and next press pulses in the same cycle → song_num unchanged, playback continues.
- rst asserted mid-PLAY → note=0, song_num=0, paused=0 without waiting for a clock edge; restart from idx 0 after release.
- With PLAYBACK_AUTO_NEXT_EN, end of song 2 → song_num=0, FETCH of address {2'd0, 0} on the next cycle, song_done pulsed once.
